// File: rtl/switch_box_pkg.sv
// switch_box_pkg: shared sizing helpers and select encodings for the configurable switch box
package switch_box_pkg;
   localparam int SEL_OFF = 0;
   localparam int PE_SEL_OFS = 0;
   function automatic int sel_w_f(input int num_sides, input int num_pe);
      return (num_sides + num_pe) > 2 ? $clog2(num_sides + num_pe) : 1;
   endfunction
   function automatic int cfg_words_f(input int cfg_bits);
      return (cfg_bits + 31) / 32;
   endfunction
endpackage

// File: rtl/sb_track_mux.sv
// sb_track_mux: decodes one output's select onto another side's same-track wire or a PE bit
module sb_track_mux import switch_box_pkg::*; #(
   parameter int NUM_SIDES = 4,
   parameter int NUM_PE = 1,
   parameter int SIDE = 0,
   localparam int SEL_W = sel_w_f(NUM_SIDES, NUM_PE)
) (
   input  logic [SEL_W-1:0]     sel_i,
   input  logic [NUM_SIDES-1:0] trk_i,
   input  logic [NUM_PE-1:0]    pe_i,
   output logic                 out_o
);
   int sel_int;
   assign sel_int = int'(sel_i);
   // other sides take selects 1.. in ascending order with own side skipped; PE bits follow
   always_comb begin
      out_o = 1'b0;
      if (sel_int != SEL_OFF) begin
         for (int i = 0; i < NUM_SIDES; i++)
            if (i != SIDE && sel_int == (i < SIDE ? i + 1 : i)) out_o = trk_i[i];
         for (int j = 0; j < NUM_PE; j++)
            if (sel_int == NUM_SIDES + PE_SEL_OFS + j) out_o = pe_i[j];
      end
   end
endmodule

// File: rtl/switch_box_cfg.sv
// switch_box_cfg: switch box with shadow/active config, atomic commit and readback; SWITCH_BOX_OUTPUT_REG_EN flops out_wires
module switch_box_cfg import switch_box_pkg::*; #(
   parameter int NUM_SIDES = 4,
   parameter int NUM_TRACKS = 4,
   parameter int NUM_PE = 1,
   parameter int ADDR_W = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SIDES*NUM_TRACKS-1:0] in_wires,
   input  logic [NUM_PE-1:0]               pe_outputs,
   output logic [NUM_SIDES*NUM_TRACKS-1:0] out_wires,
   input  logic [31:0]                     config_data,
   input  logic [ADDR_W-1:0]               config_addr,
   input  logic                            config_en,
   input  logic                            config_commit,
   output logic [31:0]                     config_rd_data,
   output logic                            config_pending,
   output logic                            config_err
);
   localparam int NO = NUM_SIDES * NUM_TRACKS;
   localparam int SEL_W = sel_w_f(NUM_SIDES, NUM_PE);
   localparam int CFG_BITS = NO * SEL_W;
   localparam int CFG_WORDS = cfg_words_f(CFG_BITS);
   localparam int PAD_BITS = CFG_WORDS * 32;
   localparam logic [PAD_BITS-1:0] CFG_MASK = PAD_BITS'({CFG_BITS{1'b1}});

   logic [PAD_BITS-1:0] shadow_q, shadow_d, wr_vec;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [31:0]         rd_q, rd_d;
   logic                pend_q, pend_d, err_q, err_d, in_rng;
   logic [NO-1:0]       mux_out;

   // address decode drives readback, shadow write, commit and status next state
   always_comb begin
      wr_vec = shadow_q;
      rd_d = '0;
      in_rng = 1'b0;
      for (int w = 0; w < CFG_WORDS; w++)
         if (config_addr == ADDR_W'(w)) begin
            in_rng = 1'b1;
            rd_d = shadow_q[w*32 +: 32];
            if (config_en) wr_vec[w*32 +: 32] = config_data;
         end
      shadow_d = wr_vec & CFG_MASK;
      active_d = config_commit ? shadow_d[CFG_BITS-1:0] : active_q;
      pend_d = !config_commit && (pend_q || (config_en && in_rng));
      err_d = err_q || (config_en && !in_rng);
   end

   // configuration state; reset discards any uncommitted shadow contents
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         shadow_q <= '0;
         active_q <= '0;
         rd_q <= '0;
         pend_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         rd_q <= rd_d;
         pend_q <= pend_d;
         err_q <= err_d;
      end

   assign config_rd_data = rd_q;
   assign config_pending = pend_q;
   assign config_err = err_q;

   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
      logic [NUM_SIDES-1:0] trk;
      for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
         assign trk[s] = in_wires[s*NUM_TRACKS+t];
         sb_track_mux #(.NUM_SIDES(NUM_SIDES), .NUM_PE(NUM_PE), .SIDE(s)) u_mux (
            .sel_i(active_q[(s*NUM_TRACKS+t)*SEL_W +: SEL_W]),
            .trk_i(trk),
            .pe_i(pe_outputs),
            .out_o(mux_out[s*NUM_TRACKS+t])
         );
      end
   end

`ifdef SWITCH_BOX_OUTPUT_REG_EN
   logic [NO-1:0] out_q;
   // retime the routed outputs by one cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) out_q <= '0;
      else out_q <= mux_out;
   assign out_wires = out_q;
`else
   assign out_wires = mux_out;
`endif
endmodule

// File: doc/switch_box_cfg.md
Name: switch_box_cfg

Overview:
- Parametrised successor to the fixed 4-side/4-track switch box: NUM_SIDES sides × NUM_TRACKS tracks plus NUM_PE PE outputs feeding every output mux.
- Adds multi-word addressed configuration into a shadow register set, an atomic commit into the active set, registered readback, and error/pending status.
- Sits between neighbouring CLB tiles and the PE, driven by the global config bus.

Parameters:
- NUM_SIDES, 4, number of switch-box sides (min 2)
- NUM_TRACKS, 4, tracks per side (min 1)
- NUM_PE, 1, PE output bits selectable onto any track (min 1)
- ADDR_W, 4, config word address width; must cover CFG_WORDS

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_wires  in  NUM_SIDES*NUM_TRACKS  flat, index s*NUM_TRACKS+t = side s track t
- pe_outputs  in  NUM_PE  PE outputs
- out_wires  out  NUM_SIDES*NUM_TRACKS  same indexing as in_wires
- config_data  in  32  write data
- config_addr  in  ADDR_W  word address for write and readback
- config_en  in  1  write strobe, one word per cycle
- config_commit  in  1  copy shadow to active
- config_rd_data  out  32  shadow word at config_addr, registered
- config_pending  out  1  shadow differs from last commit, by write history
- config_err  out  1  sticky out-of-range write flag

Behaviour:
- SEL_W = max(1, $clog2(NUM_SIDES+NUM_PE)). CFG_BITS = NUM_SIDES*NUM_TRACKS*SEL_W. CFG_WORDS = ceil(CFG_BITS/32).
- Output o = s*NUM_TRACKS+t uses active bits [o*SEL_W +: SEL_W].
- Select k for output on side s, track t:
  - k = 0: drive 0.
  - k = 1..NUM_SIDES-1: in_wires of the k-th other side in ascending order, skipping s, same track t.
  - k = NUM_SIDES..NUM_SIDES+NUM_PE-1: pe_outputs[k-NUM_SIDES].
  - Any larger k: drive 0.
- Mux path from active config to out_wires is combinational, 0 cycles from inputs.
- Write: config_en with config_addr < CFG_WORDS stores config_data into shadow word config_addr on the clk edge.
  - Bits beyond CFG_BITS in the last word are not stored and read back as 0.
  - Sets config_pending.
- Write with config_addr >= CFG_WORDS: shadow unchanged, config_err set. config_err stays set until reset.
- Commit: config_commit copies the whole shadow into active on the clk edge and clears config_pending.
  - Commit with no write pending is legal and reloads active from shadow.
- Write and commit in the same cycle: active receives the shadow including that cycle's write; config_pending ends cleared.
  - If the write is out of range, config_err still sets.
- Readback: config_rd_data updates every cycle to shadow[config_addr] as it stands before that edge's write. 1-cycle latency. Returns 0 for out-of-range addresses.
- Reset (reset low, asynchronous):
  - shadow = 0, active = 0, so all out_wires = 0.
  - config_rd_data = 0, config_pending = 0, config_err = 0.
- Reset asserted mid-write-sequence discards all shadow contents; no partial commit survives.

Optional Feature:
- SWITCH_BOX_OUTPUT_REG_EN defined: each out_wires bit is flopped on clk, giving 1-cycle latency from in_wires/pe_outputs/active to out_wires. The flops reset to 0 and are cleared asynchronously with reset.
- Undefined: out_wires is purely combinational, as specified above.

Decomposition:
- Package switch_box_pkg holds:
  - the function computing SEL_W from NUM_SIDES and NUM_PE;
  - the function computing CFG_WORDS from CFG_BITS;
  - localparam SEL_OFF = 0 and the PE select-base offset.
- One sub-module, sb_track_mux: one output's select decode, parametrised by NUM_SIDES, NUM_PE and own-side index. It is instantiated NUM_SIDES*NUM_TRACKS times via generate.

Test Plan (defaults: SEL_W=3, CFG_BITS=48, CFG_WORDS=2):
- Reset, then drive in_wires all 1 -> out_wires all 0; config_pending=0; config_err=0.
- Write addr0 = 0x00000001 with no commit -> out_wires[0]=0 and config_pending=1. Then commit -> out_wires[0] follows in_wires[4] (side 1, track 0) on the same cycle after the edge.
- Write addr1 = 0x0000FFFF, then read addr1 -> config_rd_data=0x0000FFFF one cycle later.
- Read addr1 after writing 0xFFFFFFFF -> 0x0000FFFF (bits above 48 not stored).
- Write addr2 = 0xDEADBEEF -> config_err=1, shadow readback of addr0/addr1 unchanged. config_err remains 1 after commit and clears only on reset.
- Write addr0 = 0x00000004 together with commit -> out_wires[0] = pe_outputs[0] after the edge, config_pending=0.
- Toggle pe_outputs[0] 0/1 -> out_wires[0] tracks it (1 cycle later with SWITCH_BOX_OUTPUT_REG_EN).
- Assert reset mid-sequence after a write without commit -> all outputs 0. A commit after deassert leaves outputs 0.
